// File: rtl/cap_pkg.sv
// Shared types, default widths and the round-robin search helper for capture_arbiter.
package cap_pkg;

    localparam int unsigned CAP_DW      = 16;
    localparam int unsigned CAP_NCH     = 4;
    localparam int unsigned CAP_NCH_MAX = 8;
    localparam int unsigned CAP_CW_MAX  = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_VALID = 1'b1
    } cap_state_e;

    // First set flag found from last+1 upward, wrapping modulo n; returns last when none is set.
    function automatic logic [CAP_CW_MAX-1:0] rr_next(
        input logic [CAP_NCH_MAX-1:0] flags,
        input logic [CAP_CW_MAX-1:0]  last,
        input int unsigned            n
    );
        logic [CAP_CW_MAX-1:0] r;
        logic                  found;
        int unsigned           c;
        r     = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= CAP_NCH_MAX; i++) begin
            if (i <= n && !found) begin
                c = 32'(last) + i;
                if (c >= n) c = c - n;
                if (flags[c]) begin
                    r     = CAP_CW_MAX'(c);
                    found = 1'b1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/capture_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the next pending channel after i_last.
module rr_pick
    import cap_pkg::*;
#(
    parameter  int unsigned N_CH = CAP_NCH,
    localparam int unsigned CW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] i_flags,
    input  logic [CW-1:0]   i_last,
    output logic            o_any_c,
    output logic [CW-1:0]   o_idx_c
);

    logic [CAP_CW_MAX-1:0] w_idx;

    assign w_idx   = rr_next(CAP_NCH_MAX'(i_flags), CAP_CW_MAX'(i_last), N_CH);
    assign o_any_c = |i_flags;
    assign o_idx_c = CW'(w_idx);

endmodule

// File: rtl/capture_arbiter.sv
// Round-robin arbiter sharing one valid/ready result port between N_CH capture channels.
// Optional CAP_ARB_TSTAMP_EN adds a free-running counter sampled into o_tstamp at grant.
module capture_arbiter
    import cap_pkg::*;
#(
    parameter  int unsigned N_CH = CAP_NCH,
    parameter  int unsigned DW   = CAP_DW,
    localparam int unsigned CW   = $clog2(N_CH)
) (
    input  logic             i_sysclk,
    input  logic             i_sysrst,
    input  logic             i_en,
    input  logic [N_CH-1:0]  i_ic_flg,
    input  logic [N_CH*DW-1:0] i_cnt_data,
    output logic [N_CH-1:0]  o_clr,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [DW-1:0]    o_data,
    output logic [CW-1:0]    o_ch,
`ifdef CAP_ARB_TSTAMP_EN
    output logic [DW-1:0]    o_tstamp,
`endif
    output logic             o_busy
);

    cap_state_e      r_state;
    cap_state_e      w_state_nxt;
    logic            w_grant;
    logic            w_any;
    logic [CW-1:0]   w_idx;
    logic [CW-1:0]   r_last;
    logic            r_valid;
    logic            r_busy;
    logic [N_CH-1:0] r_clr;
    logic [DW-1:0]   r_data;
    logic [CW-1:0]   r_ch;

    rr_pick #(.N_CH(N_CH)) u_rr_pick (
        .i_flags (i_ic_flg),
        .i_last  (r_last),
        .o_any_c (w_any),
        .o_idx_c (w_idx)
    );

    // State register
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and grant decision; flags and enable are ignored while a result is pending
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en && w_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_VALID;
                end
            end
            ST_VALID: begin
                if (r_valid && i_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs, latched result and round-robin pointer
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_clr   <= '0;
            r_data  <= '0;
            r_ch    <= '0;
            r_last  <= CW'(N_CH - 1);
        end else begin
            r_valid <= (w_state_nxt == ST_VALID);
            r_busy  <= (w_state_nxt == ST_VALID);
            r_clr   <= w_grant ? (N_CH'(1) << w_idx) : '0;
            if (w_grant) begin
                r_data <= i_cnt_data[w_idx*DW +: DW];
                r_ch   <= w_idx;
                r_last <= w_idx;
            end
        end
    end

`ifdef CAP_ARB_TSTAMP_EN
    logic [DW-1:0] r_cnt;
    logic [DW-1:0] r_tstamp;

    // Free-running cycle counter, sampled on the grant edge
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_cnt    <= '0;
            r_tstamp <= '0;
        end else begin
            r_cnt <= r_cnt + DW'(1);
            if (w_grant) r_tstamp <= r_cnt;
        end
    end

    assign o_tstamp = r_tstamp;
`endif

    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_clr   = r_clr;
    assign o_data  = r_data;
    assign o_ch    = r_ch;

endmodule
